// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command becomes
// one bus cycle and one response (read data or timeout error).
module wb_cmd_master #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  output logic               busy_o
);

  localparam int SW = DAT_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Ack has priority over a timeout landing in the same cycle.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          state_d     = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy_o    = (state_q != S_IDLE);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with TIMEOUT=8; inputs change and outputs
// are sampled on the falling edge.
module tb_wb_cmd_master;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;
  logic [3:0]       cmd_sel;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [DAT_W-1:0] rsp_dat;
  logic             cyc, stb, we;
  logic [3:0]       sel;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_o, dat_i;
  logic             ack, busy;

  int vecs = 0;
  int miss = 0;

  wb_cmd_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    int n;
    logic [DAT_W-1:0] hold_dat;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 0; dat_i = '0; ack = 0;
    tick(); tick();
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adr", adr, 0);
    rst = 1'b0;
    tick();

    // Write, ack in 3rd BUS cycle
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    chk("wr_stb1", stb, 1);
    chk("wr_we", we, 1);
    chk("wr_adr", adr, 32'h3000_0004);
    chk("wr_dat", dat_o, 32'hDEAD_BEEF);
    chk("wr_sel", sel, 4'hF);
    chk("wr_busy", busy, 1);
    chk("wr_cmd_ready_bus", cmd_ready, 0);
    tick();
    chk("wr_stb2", stb, 1);
    tick();
    chk("wr_stb3", stb, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("wr_cyc_drop", cyc, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_dat", rsp_dat, 0);
    chk("wr_adr_kept", adr, 32'h3000_0004);
    handshake();

    // Read, zero-wait slave
    dat_i = 32'h1234_5678;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    chk("rd_adr", adr, 32'h3000_0000);
    chk("rd_rsp_not_yet", rsp_valid, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rd_rsp_valid_lat2", rsp_valid, 1);
    chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
    chk("rd_rsp_err", rsp_err, 0);
    handshake();

    // Timeout, slave never acks
    dat_i = 32'hA5A5_A5A5;
    issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stb) break;
      n++;
      tick();
    end
    chk("to_stb_cycles", n, TO);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_dat", rsp_dat, 0);
    handshake();
    dat_i = 32'h0BAD_F00D;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    chk("to_next_stb", stb, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("to_next_dat", rsp_dat, 32'h0BAD_F00D);
    chk("to_next_err", rsp_err, 0);
    handshake();

    // Ack on the last allowed BUS cycle
    dat_i = 32'hCAFE_0008;
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("bnd_stb8", stb, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bnd_rsp_valid", rsp_valid, 1);
    chk("bnd_rsp_err", rsp_err, 0);
    chk("bnd_rsp_dat", rsp_dat, 32'hCAFE_0008);
    handshake();

    // Backpressure with a second command waiting
    dat_i = 32'h5555_AAAA;
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0044; cmd_dat = 32'h0102_0304; cmd_sel = 4'h1;
    chk("bp_adr_held", adr, 32'h3000_0040);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    hold_dat = rsp_dat;
    chk("bp_rsp_dat", hold_dat, 32'h5555_AAAA);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat_stable", rsp_dat, 32'h5555_AAAA);
      chk("bp_rsp_err", rsp_err, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_stb", stb, 0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("bp_cmd_ready_hs", cmd_ready, 0);
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_dropped", rsp_valid, 0);
    chk("bp_cmd_ready_idle", cmd_ready, 1);
    chk("bp_not_yet_stb", stb, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_cmd2_stb", stb, 1);
    chk("bp_cmd2_adr", adr, 32'h3000_0044);
    chk("bp_cmd2_we", we, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bp_cmd2_rsp_dat", rsp_dat, 0);
    handshake();

    // Reset mid-BUS with a command held, then stray ack while idle
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    chk("rstb_stb", stb, 1);
    rst = 1'b1;
    cmd_valid = 1'b1;
    tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    chk("rstb_cyc", cyc, 0);
    chk("rstb_stb0", stb, 0);
    chk("rstb_rsp_valid", rsp_valid, 0);
    chk("rstb_busy", busy, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("stray_busy", busy, 0);
    chk("stray_cyc", cyc, 0);
    tick();
    chk("stray_rsp_valid2", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic single-transfer initiator that drives the user-area Wishbone slave port from a simple valid/ready command stream, e.g. from LA-driven bring-up logic or an on-chip sequencer.
Each accepted command becomes exactly one read or write bus cycle.
Each cycle produces exactly one response carrying read data or a timeout error.
A cycle counter aborts bus cycles that never receive an ack.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width; SEL width is DAT_W/8
TIMEOUT, 255, max cycles in BUS state before abort; must be >= 1

Ports:
wb_clk_i  input  1  clock, all logic rising-edge
wb_rst_i  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_we  input  1  1 = write, 0 = read
cmd_adr  input  ADR_W  byte address
cmd_dat  input  DAT_W  write data
cmd_sel  input  DAT_W/8  byte enables
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_dat  output  DAT_W  read data; 0 for writes and errors
rsp_err  output  1  1 = timeout abort
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  DAT_W/8  Wishbone byte select
wbm_adr_o  output  ADR_W  Wishbone address
wbm_dat_o  output  DAT_W  Wishbone write data
wbm_dat_i  input  DAT_W  Wishbone read data
wbm_ack_i  input  1  Wishbone acknowledge
busy_o  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered except cmd_ready and busy_o, which decode the state register.
- Reset values:
  - state IDLE.
  - cyc, stb, we = 0; sel, adr, dat_o = 0.
  - rsp_valid = 0, rsp_dat = 0, rsp_err = 0.
  - Timeout counter = 0.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid in cycle N: latch we/adr/dat/sel onto the wbm_* outputs, set cyc = stb = 1, clear the counter, go to BUS.
  - Bus signals are first visible in cycle N+1.
- BUS:
  - cmd_ready = 0; cyc, stb and all wbm_* outputs held stable.
  - Counter increments each cycle.
  - On wbm_ack_i sampled high in cycle M:
    - cyc = stb = 0 from M+1.
    - For reads, rsp_dat = wbm_dat_i sampled at M; for writes, rsp_dat = 0.
    - rsp_err = 0, rsp_valid = 1 from M+1, go to RESP.
    - Minimum command-to-response latency: 2 cycles after acceptance with zero-wait slave.
  - If the counter reaches TIMEOUT-1 with no ack in that cycle: drop cyc/stb, rsp_err = 1, rsp_dat = 0, rsp_valid = 1, go to RESP.
  - The abort takes effect exactly TIMEOUT cycles after stb first asserted.
  - Ack and timeout in the same cycle: ack wins, rsp_err = 0.
- RESP:
  - rsp_valid and rsp_* held stable until rsp_ready = 1.
  - On that edge: rsp_valid = 0, go to IDLE.
  - cmd_ready = 0 throughout RESP, so there is no command/response overlap.
  - Next command is accepted no earlier than the cycle after the handshake.
- wbm_ack_i in IDLE or RESP is ignored; no state or output change.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o keep their last values after the cycle ends; only cyc/stb return to 0.
- Reset mid-operation, in any state: next edge forces reset values.
  - cyc/stb drop.
  - Any pending response is discarded.
  - A command presented during reset is not accepted.
- Counter width: $clog2(TIMEOUT+1); counter saturates and never wraps.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks in 3rd BUS cycle.
  - Required: wbm_* match the command.
  - cyc/stb high for exactly 3 cycles.
  - rsp_valid=1 with rsp_err=0, rsp_dat=0.
- Read: zero-wait slave returns 0x1234_5678 at adr 0x3000_0000.
  - Required: rsp_dat=0x1234_5678, rsp_err=0.
  - rsp_valid rises 2 cycles after the cmd handshake.
- Timeout: TIMEOUT=8, slave never acks.
  - Required: stb high exactly 8 cycles, then drops.
  - rsp_err=1, rsp_dat=0.
  - Next command is accepted normally.
- Boundary: with TIMEOUT=8, ack arrives in the 8th BUS cycle.
  - Required: rsp_err=0 and valid read data.
- Backpressure: rsp_ready held low for 5 cycles; cmd_valid held high with a second command.
  - Required: rsp_* stable and cmd_ready=0 throughout.
  - Second command is accepted the cycle after the rsp handshake.
- Reset mid-BUS: assert wb_rst_i for 1 cycle while stb=1; also drive a stray ack while IDLE.
  - Required: cyc/stb=0 next cycle, no rsp_valid, busy_o=0.
  - Stray ack produces no response.
